watch_ctrl: RTL

Timekeeping and display-sequencing controller for the four-digit HH:MM watch. It keeps hours, minutes and seconds, and runs the calibration state machine driven by the mode and increment buttons. It also scans the four display positions. It drives the seven-segment decode/digit-select stage through `control_dig`, `sel`, `key` and `sec_en`, and sits between the debounced button logic and that stage.

---
 rtl/watch_pkg.sv | 49 ++++
 rtl/watch_tick_gen.sv | 85 ++++++++
 rtl/watch_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// ---------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the HH:MM watch controller:
//   - calibration state codes (the state code is also the value shown on
//     control_dig, so the codes are fixed, not free encodings)
//   - per-digit modulus limits for the time registers
//   - display scan positions
//   - incMod helper used for both calibration increments and run carries
// ---------------------------------------------------------------------------
package watch_pkg;

    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_SET_HH_T = 3'd4;
    localparam logic [2:0] ST_SET_HH_U = 3'd3;
    localparam logic [2:0] ST_SET_MM_T = 3'd2;
    localparam logic [2:0] ST_SET_MM_U = 3'd1;

    typedef enum logic [2:0] {
        STATE_RUN      = ST_RUN,
        STATE_SET_HH_T = ST_SET_HH_T,
        STATE_SET_HH_U = ST_SET_HH_U,
        STATE_SET_MM_T = ST_SET_MM_T,
        STATE_SET_MM_U = ST_SET_MM_U
    } state_e;

    localparam logic [3:0] LIM_MM_U    = 4'd10;
    localparam logic [3:0] LIM_MM_T    = 4'd6;
    localparam logic [3:0] LIM_HH_T    = 4'd3;
    localparam logic [3:0] LIM_HH_U    = 4'd10;
    localparam logic [3:0] LIM_HH_U_HI = 4'd4;
    localparam logic [5:0] LIM_SEC     = 6'd60;

    // Highest legal hour-tens value; at this value hour-units is limited
    // to LIM_HH_U_HI so that the hour never exceeds 23.
    localparam logic [3:0] HH_T_MAX    = 4'd2;

    localparam logic [1:0] POS_HH_T = 2'd0;
    localparam logic [1:0] POS_HH_U = 2'd1;
    localparam logic [1:0] POS_MM_T = 2'd2;
    localparam logic [1:0] POS_MM_U = 2'd3;

    // Increment a BCD digit modulo 'limit'. The >= test also folds any
    // out-of-range value back to zero instead of letting it run away.
    function automatic logic [3:0] incMod(input logic [3:0] value,
                                          input logic [3:0] limit);
        return (value >= limit - 4'd1) ? 4'd0 : value + 4'd1;
    endfunction

endpackage

// File: rtl/watch_tick_gen.sv
// ---------------------------------------------------------------------------
// watch_tick_gen
// Time base for the watch: one-second divider, half-second blink phase and
// the display scan position counter.
//
// Ports:
//   clk_i        in   1  clock
//   rst_i        in   1  synchronous active-high reset
//   restart_i    in   1  restart the second divider and blink phase
//   secStrobe_o  out  1  high on the last clock of every TICK_DIV period
//   secEn_o      out  1  registered blink phase, high for the first half
//   sel_o        out  2  registered scan position
//   selNext_o    out  2  scan position that sel_o takes on the next edge
// ---------------------------------------------------------------------------
module watch_tick_gen
    import watch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       restart_i,
    output logic       secStrobe_o,
    output logic       secEn_o,
    output logic [1:0] sel_o,
    output logic [1:0] selNext_o
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICK_DIV / 2);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [TW-1:0] tickCnt_q, tickCnt_d;
    logic          secEn_q, secEn_d;
    logic [SW-1:0] scanCnt_q, scanCnt_d;
    logic [1:0]    sel_q, sel_d;

    assign secStrobe_o = (tickCnt_q == TICK_LAST);

    // Second divider and blink phase. The blink register is derived from
    // the next counter value so that it is high exactly while the counter
    // sits in the first half of the period, and a restart lines it up with
    // the fresh second.
    always_comb begin
        tickCnt_d = tickCnt_q + TW'(1);
        if (restart_i || secStrobe_o) begin
            tickCnt_d = '0;
        end
        secEn_d = (tickCnt_d < TICK_HALF);
    end

    // Scan divider: sel advances once every SCAN_DIV clocks in every state
    // and is never disturbed by the calibration restart.
    always_comb begin
        scanCnt_d = scanCnt_q + SW'(1);
        sel_d     = sel_q;
        if (scanCnt_q == SCAN_LAST) begin
            scanCnt_d = '0;
            sel_d     = (sel_q == POS_MM_U) ? POS_HH_T : sel_q + 2'd1;
        end
    end

    // State registers for both dividers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tickCnt_q <= '0;
            secEn_q   <= 1'b1;
            scanCnt_q <= '0;
            sel_q     <= POS_HH_T;
        end else begin
            tickCnt_q <= tickCnt_d;
            secEn_q   <= secEn_d;
            scanCnt_q <= scanCnt_d;
            sel_q     <= sel_d;
        end
    end

    assign secEn_o   = secEn_q;
    assign sel_o     = sel_q;
    assign selNext_o = sel_d;

endmodule

// File: rtl/watch_ctrl.sv
// ---------------------------------------------------------------------------
// watch_ctrl
// Timekeeping and display sequencing for a four-digit HH:MM watch. Keeps
// hours, minutes and seconds, runs the mode/increment calibration FSM and
// feeds the seven-segment stage with the digit at the current scan position.
//
// Ports:
//   clk          in   1  clock
//   rst          in   1  synchronous active-high reset
//   key_mode     in   1  debounced pulse, steps the calibration state
//   key_inc      in   1  debounced pulse, increments the selected digit
//   control_dig  out  3  state code: 0 run, 4/3/2/1 digit being set
//   sel          out  2  scan position 0..3 (hour-tens .. minute-units)
//   key          out  4  BCD value of the digit at sel
//   sec_en       out  1  blink phase, high in the first half of a second
//
// Build option: define WATCH_SET_TIMEOUT_EN to leave calibration
// automatically after TIMEOUT_S idle seconds.
// ---------------------------------------------------------------------------
module watch_ctrl
    import watch_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int SCAN_DIV  = 50_000,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [2:0] control_dig,
    output logic [1:0] sel,
    output logic [3:0] key,
    output logic       sec_en
);

    // Parameter sanity checks at elaboration time.
    if (TICK_DIV < 4 || (TICK_DIV % 2) != 0) begin : g_badTickDiv
        $error("watch_ctrl: TICK_DIV must be even and at least 4");
    end
    if (SCAN_DIV < 1 || TIMEOUT_S < 1) begin : g_badDiv
        $error("watch_ctrl: SCAN_DIV and TIMEOUT_S must be at least 1");
    end

    state_e     state_q, state_d;
    logic [3:0] hourTens_q, hourTens_d;
    logic [3:0] hourUnits_q, hourUnits_d;
    logic [3:0] minTens_q, minTens_d;
    logic [3:0] minUnits_q, minUnits_d;
    logic [5:0] sec_q, sec_d;
    logic [3:0] key_q, key_d;
    logic       restart;
    logic       secStrobe;
    logic [1:0] selNext;

    watch_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) u_tickGen (
        .clk_i       (clk),
        .rst_i       (rst),
        .restart_i   (restart),
        .secStrobe_o (secStrobe),
        .secEn_o     (sec_en),
        .sel_o       (sel),
        .selNext_o   (selNext)
    );

`ifdef WATCH_SET_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    // Next-state logic for the FSM and the time registers. Mode has
    // priority over inc, so a simultaneous inc is simply dropped. The
    // run-time carry chain only fires in RUN, which freezes the time
    // during calibration while the dividers keep running.
    always_comb begin
        state_d     = state_q;
        hourTens_d  = hourTens_q;
        hourUnits_d = hourUnits_q;
        minTens_d   = minTens_q;
        minUnits_d  = minUnits_q;
        sec_d       = sec_q;
        restart     = 1'b0;

        if (key_mode) begin
            unique case (state_q)
                STATE_RUN:      state_d = STATE_SET_HH_T;
                STATE_SET_HH_T: state_d = STATE_SET_HH_U;
                STATE_SET_HH_U: state_d = STATE_SET_MM_T;
                STATE_SET_MM_T: state_d = STATE_SET_MM_U;
                STATE_SET_MM_U: begin
                    state_d = STATE_RUN;
                    sec_d   = '0;
                    restart = 1'b1;
                end
                default:        state_d = STATE_RUN;
            endcase
        end else if (key_inc) begin
            unique case (state_q)
                STATE_SET_HH_T: begin
                    hourTens_d = incMod(hourTens_q, LIM_HH_T);
                    // Entering the 20s must never leave an hour of 24..29.
                    if (hourTens_d == HH_T_MAX && hourUnits_q > LIM_HH_U_HI - 4'd1) begin
                        hourUnits_d = LIM_HH_U_HI - 4'd1;
                    end
                end
                STATE_SET_HH_U: begin
                    hourUnits_d = incMod(hourUnits_q,
                                         (hourTens_q == HH_T_MAX) ? LIM_HH_U_HI : LIM_HH_U);
                end
                STATE_SET_MM_T: minTens_d  = incMod(minTens_q, LIM_MM_T);
                STATE_SET_MM_U: minUnits_d = incMod(minUnits_q, LIM_MM_U);
                default: ;
            endcase
        end

        if (state_q == STATE_RUN && secStrobe) begin
            if (sec_q == LIM_SEC - 6'd1) begin
                sec_d      = '0;
                minUnits_d = incMod(minUnits_q, LIM_MM_U);
                if (minUnits_q == LIM_MM_U - 4'd1) begin
                    minTens_d = incMod(minTens_q, LIM_MM_T);
                    if (minTens_q == LIM_MM_T - 4'd1) begin
                        if (hourTens_q == HH_T_MAX && hourUnits_q == LIM_HH_U_HI - 4'd1) begin
                            hourTens_d  = '0;
                            hourUnits_d = '0;
                        end else if (hourUnits_q == LIM_HH_U - 4'd1) begin
                            hourUnits_d = '0;
                            hourTens_d  = hourTens_q + 4'd1;
                        end else begin
                            hourUnits_d = hourUnits_q + 4'd1;
                        end
                    end
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

`ifdef WATCH_SET_TIMEOUT_EN
        // Idle timeout: count second strobes while calibrating with no
        // button activity; the last one forces a normal exit to RUN.
        idle_d = '0;
        if (state_q != STATE_RUN && !key_mode && !key_inc && secStrobe) begin
            if (idle_q == IDLE_LAST) begin
                state_d = STATE_RUN;
                sec_d   = '0;
                restart = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end else if (state_q != STATE_RUN && !key_mode && !key_inc) begin
            idle_d = idle_q;
        end
`endif
    end

    // The key mux looks ahead at the scan position being entered so that
    // key and sel change on the same edge, using this cycle's digits.
    always_comb begin
        unique case (selNext)
            POS_HH_T: key_d = hourTens_q;
            POS_HH_U: key_d = hourUnits_q;
            POS_MM_T: key_d = minTens_q;
            default:  key_d = minUnits_q;
        endcase
    end

    // FSM state, time registers and the registered key output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STATE_RUN;
            hourTens_q  <= '0;
            hourUnits_q <= '0;
            minTens_q   <= '0;
            minUnits_q  <= '0;
            sec_q       <= '0;
            key_q       <= '0;
        end else begin
            state_q     <= state_d;
            hourTens_q  <= hourTens_d;
            hourUnits_q <= hourUnits_d;
            minTens_q   <= minTens_d;
            minUnits_q  <= minUnits_d;
            sec_q       <= sec_d;
            key_q       <= key_d;
        end
    end

`ifdef WATCH_SET_TIMEOUT_EN
    // Idle second counter for the calibration timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign control_dig = state_q;
    assign key         = key_q;

endmodule
